csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_accumulator.sv | 133 +++++++++++++
 tb/tb_csa_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: operands are summed in redundant (S, C) form with no
// carry chain, then resolved CHUNK bits per cycle into a binary group sum.
module csa_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count
);

  localparam int NCHUNK = ACC_W / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic             cy_q, cy_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [7:0]       out_count_q, out_count_d;

  logic [ACC_W-1:0] d_ext;
  logic [CHUNK:0]   slice_add;
  int               k_idx;

  assign d_ext     = ACC_W'(in_data);
  assign k_idx     = int'(k_q);
  assign slice_add = {1'b0, s_q[k_idx*CHUNK +: CHUNK]}
                   + {1'b0, c_q[k_idx*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cy_q};

  // out_valid is masked by rst so a reset arriving mid-OUT never presents a result.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT) && !rst;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    cy_d        = cy_q;
    res_d       = res_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;

    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d   = s_q ^ c_q ^ d_ext;
          c_d   = ((s_q & c_q) | (c_q & d_ext) | (d_ext & s_q)) << 1;
          cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          if (in_last) begin
            state_d = RESOLVE;
            k_d     = '0;
            cy_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        res_d[k_idx*CHUNK +: CHUNK] = slice_add[CHUNK-1:0];
        cy_d = slice_add[CHUNK];
        k_d  = k_q + K_ONE;
        // Top-slice carry-out is simply dropped: the sum wraps modulo 2^ACC_W.
        if (k_q == K_LAST) begin
          state_d     = OUT;
          k_d         = '0;
          out_sum_d   = res_d;
          out_count_d = cnt_q;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = ACCUM;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      cy_q        <= 1'b0;
      res_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      cy_q        <= cy_d;
      res_q       <= res_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator at N=4, ACC_W=8, CHUNK=4: table of
// groups plus hand sequences for wrap, saturation, backpressure and resets.
module tb_csa_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [7:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  csa_accumulator #(.N(4), .ACC_W(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ops;      // up to four operands, operand i in nibble i
    int          n;
    logic [7:0]  exp_sum;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one beat from a negedge and lets it be taken on the next posedge.
  task automatic send_beat(input logic [3:0] v, input logic last);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_beat", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    @(posedge clk);
  endtask

  task automatic send_group(input logic [15:0] ops, input int n);
    for (int i = 0; i < n; i++) send_beat(ops[4*i +: 4], (i == n - 1));
  endtask

  task automatic send_repeat(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) send_beat(v, (i == n - 1));
  endtask

  // Counts edges from the in_last acceptance to out_valid, then checks the result.
  task automatic wait_result(input string name, input logic [7:0] es, input logic [7:0] ec);
    int edges = 0;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    while (!out_valid && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"}, 32'(edges), 2);
    check({name, "_sum"}, 32'(out_sum), 32'(es));
    check({name, "_count"}, 32'(out_count), 32'(ec));
  endtask

  // With out_ready high the handshake lands on the next edge.
  task automatic after_handshake(input string name, input logic [7:0] es, input logic [7:0] ec);
    @(negedge clk);
    check({name, "_post_valid"}, 32'(out_valid), 0);
    check({name, "_post_ready"}, 32'(in_ready), 1);
    check({name, "_retain_sum"}, 32'(out_sum), 32'(es));
    check({name, "_retain_cnt"}, 32'(out_count), 32'(ec));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ops: 16'h0FFF, n: 3, exp_sum: 8'h2D, exp_cnt: 8'd3};
    vecs[1] = '{ops: 16'h0009, n: 1, exp_sum: 8'h09, exp_cnt: 8'd1};
    vecs[2] = '{ops: 16'h4321, n: 4, exp_sum: 8'h0A, exp_cnt: 8'd4};
    vecs[3] = '{ops: 16'h0088, n: 2, exp_sum: 8'h10, exp_cnt: 8'd2};
    vecs[4] = '{ops: 16'h0000, n: 1, exp_sum: 8'h00, exp_cnt: 8'd1};
    vecs[5] = '{ops: 16'hCDEF, n: 4, exp_sum: 8'h36, exp_cnt: 8'd4};
    vecs[6] = '{ops: 16'h0CA6, n: 3, exp_sum: 8'h1C, exp_cnt: 8'd3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_sum", 32'(out_sum), 0);
    check("reset_out_count", 32'(out_count), 0);

    for (int v = 0; v < 7; v++) begin
      send_group(vecs[v].ops, vecs[v].n);
      wait_result($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt);
      after_handshake($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt);
    end

    // 18 x 15 = 270, wraps to 0x0E
    send_repeat(4'hF, 18);
    wait_result("wrap", 8'h0E, 8'd18);
    after_handshake("wrap", 8'h0E, 8'd18);

    // 260 x 1: sum wraps to 0x04, count saturates at 255
    send_repeat(4'h1, 260);
    wait_result("saturate", 8'h04, 8'd255);
    after_handshake("saturate", 8'h04, 8'd255);

    // Backpressure: result must hold and no input beat may be taken
    out_ready = 1'b0;
    send_group(16'h0065, 2);
    wait_result("bp", 8'h0B, 8'd2);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_data  = 4'hF;
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_in_ready", 32'(in_ready), 0);
      check("bp_hold_sum", 32'(out_sum), 32'h0B);
      check("bp_hold_count", 32'(out_count), 2);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    after_handshake("bp", 8'h0B, 8'd2);
    send_group(16'h0001, 1);
    wait_result("bp_next", 8'h01, 8'd1);
    after_handshake("bp_next", 8'h01, 8'd1);

    // Reset during OUT: out_valid drops while rst is high, result cleared
    out_ready = 1'b0;
    send_group(16'h0003, 1);
    wait_result("rst_out", 8'h03, 8'd1);
    rst = 1'b1;
    #1;
    check("rst_out_valid_during_rst", 32'(out_valid), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    check("rst_out_sum_cleared", 32'(out_sum), 0);
    check("rst_out_cnt_cleared", 32'(out_count), 0);
    @(negedge clk);
    check("rst_out_in_ready", 32'(in_ready), 1);
    check("rst_out_valid_after", 32'(out_valid), 0);

    // Reset on the first RESOLVE cycle: result must never appear
    send_beat(4'h7, 1'b0);
    send_beat(4'h7, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_resolve_no_valid", 32'(out_valid), 0);
      @(negedge clk);
    end
    check("rst_resolve_in_ready", 32'(in_ready), 1);
    check("rst_resolve_sum_cleared", 32'(out_sum), 0);
    send_group(16'h0043, 2);
    wait_result("rst_resolve_next", 8'h07, 8'd2);
    after_handshake("rst_resolve_next", 8'h07, 8'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
